// File: rtl/register_file.sv
// 32 x 32-bit MIPS GPR file: one WB write port, two combinational ID read ports, $0 hardwired to zero.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WB_RegDest,
    input  logic [DATA_W-1:0] WB_WriteReg,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_en;

    assign write_en = RegWrite && !reset && (WB_RegDest != '0);

    // Storage; index 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (write_en) begin
            regs[WB_RegDest] <= WB_WriteReg;
        end
    end

    // Read ports; the bypass term forwards a write in flight to a matching reader.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadReg1 != '0) begin
            ReadData1 = regs[ReadReg1];
        end
        if (ReadReg2 != '0) begin
            ReadData2 = regs[ReadReg2];
        end
`ifdef REGFILE_BYPASS_EN
        if (write_en && (WB_RegDest == ReadReg1)) begin
            ReadData1 = WB_WriteReg;
        end
        if (write_en && (WB_RegDest == ReadReg2)) begin
            ReadData2 = WB_WriteReg;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; expectations adapt to REGFILE_BYPASS_EN.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WB_RegDest;
    logic [31:0] WB_WriteReg;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int total = 0;
    int bad   = 0;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .WB_RegDest (WB_RegDest),
        .WB_WriteReg(WB_WriteReg),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] wdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] exp1;   // expected before the edge, without bypass
        logic [31:0] exp2;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Same-cycle bypass expectation when compiled in; otherwise the pre-write value.
    function automatic logic [31:0] with_bypass(input vec_t v, input logic [4:0] r,
                                                input logic [31:0] base);
`ifdef REGFILE_BYPASS_EN
        if (v.we && (v.dest == r) && (r != 5'd0)) return v.wdata;
`endif
        return base;
    endfunction

    task automatic drive(input logic we, input logic [4:0] d, input logic [31:0] w,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite    = we;
        WB_RegDest  = d;
        WB_WriteReg = w;
        ReadReg1    = r1;
        ReadReg2    = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        vec_t        cur;

        vecs[0]  = '{1'b1, 5'd8,  32'h1234_5678, 5'd8,  5'd8,  32'h0,         32'h0};
        vecs[1]  = '{1'b0, 5'd8,  32'h0,         5'd8,  5'd8,  32'h1234_5678, 32'h1234_5678};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd8,  32'h0,         32'h1234_5678};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
        vecs[4]  = '{1'b1, 5'd9,  32'h1,         5'd9,  5'd9,  32'h0,         32'h0};
        vecs[5]  = '{1'b1, 5'd9,  32'h2,         5'd9,  5'd9,  32'h1,         32'h1};
        vecs[6]  = '{1'b0, 5'd9,  32'h0,         5'd9,  5'd9,  32'h2,         32'h2};
        vecs[7]  = '{1'b0, 5'd3,  32'hAAAA_5555, 5'd3,  5'd8,  32'h0,         32'h1234_5678};
        vecs[8]  = '{1'b0, 5'd3,  32'hAAAA_5555, 5'd3,  5'd8,  32'h0,         32'h1234_5678};
        vecs[9]  = '{1'b0, 5'd3,  32'hAAAA_5555, 5'd3,  5'd8,  32'h0,         32'h1234_5678};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  32'h0,         32'h0};
        vecs[11] = '{1'b1, 5'd10, 32'h11,        5'd10, 5'd0,  32'h0,         32'h0};
        vecs[12] = '{1'b1, 5'd10, 32'h22,        5'd10, 5'd10, 32'h11,        32'h11};
        vecs[13] = '{1'b0, 5'd0,  32'h0,         5'd10, 5'd10, 32'h22,        32'h22};

        reset = 1'b1;
        drive(1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd31);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd1", ReadData1, 32'h0);
        chk("reset_rd2", ReadData2, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
        #1;
        chk("post_reset_rd1", ReadData1, 32'h0);
        chk("post_reset_rd2", ReadData2, 32'h0);

        // Table: drive at negedge, sample before the next posedge performs the write.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            cur = vecs[i];
            drive(cur.we, cur.dest, cur.wdata, cur.r1, cur.r2);
            #1;
            chk($sformatf("vec%0d_rd1", i), ReadData1, with_bypass(cur, cur.r1, cur.exp1));
            chk($sformatf("vec%0d_rd2", i), ReadData2, with_bypass(cur, cur.r2, cur.exp2));
        end

        // Asynchronous reset mid-cycle clears a live value before any edge.
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        chk("pre_reset_r5", ReadData1, 32'hDEAD_BEEF);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_r5", ReadData1, 32'h0);
        drive(1'b1, 5'd5, 32'h0000_0055, 5'd5, 5'd5);
        #1;
        chk("reset_bypass_blocked", ReadData2, 32'h0);
        @(negedge clk);
        #1;
        chk("write_in_reset_rd1", ReadData1, 32'h0);
        chk("write_in_reset_rd2", ReadData2, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 5'd6, 32'h0000_0066, 5'd6, 5'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        v1 = 32'h0000_0066;
`else
        v1 = 32'h0;
`endif
        chk("first_write_pre_edge", ReadData1, v1);
        chk("r5_still_clear", ReadData2, 32'h0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd5);
        #1;
        chk("first_write_landed", ReadData1, 32'h0000_0066);
        chk("r5_after_reset", ReadData2, 32'h0);

        // Sweep: fill 1..31, then read complementary pairs.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            v1 = 32'(i) * 32'h0101_0101;
            v2 = 32'(31 - i) * 32'h0101_0101;
            #1;
            chk($sformatf("sweep_rd1_%0d", i), ReadData1, v1);
            chk($sformatf("sweep_rd2_%0d", 31 - i), ReadData2, v2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
